// File: rtl/psg_player_pkg.sv
// Shared types for the SN76489 command player.
//   state_e  : player FSM states
//   OP_WRITE : command opcode, argument low byte goes to the PSG
//   OP_WAIT  : command opcode, argument is a delay in clock cycles
// The command record itself is declared in psg_cmd_player, because its
// argument width follows that module's WAIT_W parameter and a package
// cannot carry a parameter.
package psg_player_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_RECOVER = 3'd3,
        S_WAIT    = 3'd4
    } state_e;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_WAIT  = 1'b1;

endpackage

// File: rtl/psg_cmd_fifo.sv
// Synchronous FIFO for player commands.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_flush        : synchronous clear; it wins over a push or pop in the same cycle
//   i_push/i_data  : write side; the push is ignored when the FIFO is full
//   i_pop/o_data   : read side; o_data shows the head entry, i_pop advances past it
//   o_full/o_empty/o_level : occupancy status
module psg_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 17
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_push;
    logic         w_pop;

    assign w_push = i_push && !o_full  && !i_flush;
    assign w_pop  = i_pop  && !o_empty && !i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    // The extra pointer bit tells full apart from empty when the index bits match.
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/psg_cmd_player.sv
// Queues WRITE and WAIT commands and replays them on the byte-write port of
// the SN76489 core, with a timed write strobe and a READY handshake.
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_ena                : run enable; 0 pauses playback (a write in flight still finishes)
//   i_flush              : empties the queue and aborts a WAIT
//   i_cmd_valid/o_cmd_ready, i_cmd_op, i_cmd_arg : command input
//   o_psg_data, o_psg_we_n, i_psg_ready : PSG write port
//   o_busy, o_level, o_err : status; o_err is a sticky strobe timeout
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_IDLE    | pop the next command when enabled and the queue holds one
// S_SETUP   | byte presented, strobe still high (one cycle)
// S_STROBE  | strobe low until hold time met and READY seen, or timeout
// S_RECOVER | strobe high again, byte held (one cycle)
// S_WAIT    | down-count the WAIT argument while enabled
module psg_cmd_player #(
    parameter int DEPTH   = 8,
    parameter int WAIT_W  = 16,
    parameter int WR_HOLD = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_ena,
    input  logic                    i_flush,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_op,
    input  logic [WAIT_W-1:0]       i_cmd_arg,
    output logic [7:0]              o_psg_data,
    output logic                    o_psg_we_n,
    input  logic                    i_psg_ready,
    output logic                    o_busy,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_err
);
    import psg_player_pkg::*;

    typedef struct packed {
        logic              op;
        logic [WAIT_W-1:0] arg;
    } cmd_t;

    localparam int SC_W = $clog2(TIMEOUT);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [7:0]        r_data;
    logic [7:0]        w_data_nxt;
    logic              r_we_n;
    logic              r_err;
    logic              w_err_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic [SC_W-1:0]   r_strb_cnt;
    logic [SC_W-1:0]   w_strb_nxt;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_hold_ok;
    cmd_t              w_push_cmd;
    cmd_t              w_head;

    assign w_push_cmd = '{op: i_cmd_op, arg: i_cmd_arg};

    psg_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(cmd_t))
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_push  (i_cmd_valid),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );

    // The strobe timer loads TIMEOUT-1 on the first low cycle, so the value
    // TIMEOUT-WR_HOLD marks the cycle on which the hold time is reached and
    // zero marks the last allowed cycle.
    assign w_hold_ok = (r_strb_cnt <= SC_W'(TIMEOUT - WR_HOLD));

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_err_nxt   = r_err;
        w_wait_nxt  = r_wait_cnt;
        w_strb_nxt  = r_strb_cnt;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_ena && !w_empty && !i_flush) begin
                    w_pop = 1'b1;
                    if (w_head.op == OP_WRITE) begin
                        w_data_nxt  = w_head.arg[7:0];
                        w_state_nxt = S_SETUP;
                    end else if (w_head.arg != '0) begin
                        w_wait_nxt  = w_head.arg;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_SETUP: begin
                w_strb_nxt  = SC_W'(TIMEOUT - 1);
                w_state_nxt = S_STROBE;
            end
            S_STROBE: begin
                if (w_hold_ok && i_psg_ready) begin
                    w_state_nxt = S_RECOVER;
                end else if (r_strb_cnt == '0) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_RECOVER;
                end else begin
                    w_strb_nxt = r_strb_cnt - 1'b1;
                end
            end
            S_RECOVER: begin
                w_state_nxt = S_IDLE;
            end
            S_WAIT: begin
                if (i_flush) begin
                    w_state_nxt = S_IDLE;
                end else if (i_ena) begin
                    if (r_wait_cnt == WAIT_W'(1)) w_state_nxt = S_IDLE;
                    else                          w_wait_nxt  = r_wait_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_data     <= '0;
            r_we_n     <= 1'b1;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
            r_strb_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_data     <= w_data_nxt;
            r_we_n     <= (w_state_nxt != S_STROBE);
            r_err      <= w_err_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_strb_cnt <= w_strb_nxt;
        end
    end

    assign o_psg_data  = r_data;
    assign o_psg_we_n  = r_we_n;
    assign o_err       = r_err;
    assign o_cmd_ready = !w_full;
    assign o_busy      = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_psg_cmd_player.sv
module tb_psg_cmd_player;
    localparam int WAIT_W = 16;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_ena;
    logic              i_flush;
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic              i_cmd_op;
    logic [WAIT_W-1:0] i_cmd_arg;
    logic [7:0]        o_psg_data;
    logic              o_psg_we_n;
    logic              i_psg_ready;
    logic              o_busy;
    logic [3:0]        o_level;
    logic              o_err;

    psg_cmd_player #(
        .DEPTH   (8),
        .WAIT_W  (WAIT_W),
        .WR_HOLD (2),
        .TIMEOUT (64)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_ena       (i_ena),
        .i_flush     (i_flush),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_op    (i_cmd_op),
        .i_cmd_arg   (i_cmd_arg),
        .o_psg_data  (o_psg_data),
        .o_psg_we_n  (o_psg_we_n),
        .i_psg_ready (i_psg_ready),
        .o_busy      (o_busy),
        .o_level     (o_level),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // strobe monitor: falling-edge cycle, byte on the bus, low width
    logic       prev_we_n = 1'b1;
    int         last_fall = 0;
    int         q_fall[$];
    logic [7:0] q_data[$];
    int         q_width[$];

    always @(negedge i_clk) begin
        if (prev_we_n && !o_psg_we_n) begin
            q_fall.push_back(cyc);
            q_data.push_back(o_psg_data);
            last_fall = cyc;
        end
        if (!prev_we_n && o_psg_we_n) q_width.push_back(cyc - last_fall);
        prev_we_n = o_psg_we_n;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int push_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mon_clear();
        q_fall.delete();
        q_data.delete();
        q_width.delete();
    endtask

    // all drive tasks are entered and left at posedge+1
    task automatic sync();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic op, input logic [WAIT_W-1:0] arg);
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_arg   = arg;
        push_cyc    = cyc;
        sync();
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (o_busy && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        chk(tag, o_busy, 1'b0);
        sync();
    endtask

    initial begin
        int first_push;
        int n;
        i_rst_n     = 1'b0;
        i_ena       = 1'b0;
        i_flush     = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_op    = 1'b0;
        i_cmd_arg   = '0;
        i_psg_ready = 1'b1;
        #8;
        chk("rst_we_n",  o_psg_we_n,  1'b1);
        chk("rst_data",  o_psg_data,  8'h00);
        chk("rst_ready", o_cmd_ready, 1'b1);
        chk("rst_busy",  o_busy,      1'b0);
        chk("rst_level", o_level,     4'd0);
        chk("rst_err",   o_err,       1'b0);
        #4 i_rst_n = 1'b1;
        sync();

        // two back-to-back writes, READY tied high
        i_ena = 1'b1;
        mon_clear();
        push(1'b0, 16'h009F);
        first_push = push_cyc;
        push(1'b0, 16'h0080);
        wait_idle("idle_b2b", 100);
        chk("b2b_count",   q_fall.size(), 2);
        chk("b2b_latency", q_fall[0] - first_push, 3);
        chk("b2b_data0",   q_data[0], 8'h9F);
        chk("b2b_data1",   q_data[1], 8'h80);
        chk("b2b_width0",  q_width[0], 2);
        chk("b2b_width1",  q_width[1], 2);
        chk("b2b_spacing", q_fall[1] - q_fall[0], 5);

        // write, wait 10, write: 5 write cycles + 11 wait cycles
        mon_clear();
        push(1'b0, 16'h0090);
        push(1'b1, 16'd10);
        push(1'b0, 16'h0091);
        wait_idle("idle_wait", 100);
        chk("wait_count",   q_fall.size(), 2);
        chk("wait_data1",   q_data[1], 8'h91);
        chk("wait_spacing", q_fall[1] - q_fall[0], 16);

        // fill while paused, overflow attempt, then replay
        mon_clear();
        i_ena = 1'b0;
        for (int i = 0; i < 8; i++) push(1'b0, 16'(8'h10 + i));
        chk("full_level", o_level, 4'd8);
        chk("full_ready", o_cmd_ready, 1'b0);
        chk("full_busy",  o_busy, 1'b1);
        chk("pause_nostrobe", q_fall.size(), 0);
        push(1'b0, 16'h0055);
        chk("ovf_level", o_level, 4'd8);
        i_ena = 1'b1;
        wait_idle("idle_replay", 200);
        chk("replay_count", q_fall.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("replay_data%0d", i), q_data[i], 32'(8'h10 + i));

        // strobe timeout with READY low, next command still plays
        mon_clear();
        i_psg_ready = 1'b0;
        push(1'b0, 16'h00A5);
        push(1'b0, 16'h00A6);
        n = 0;
        while (q_width.size() == 0 && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        chk("tmo_seen",  q_width.size(), 1);
        chk("tmo_width", q_width[0], 64);
        chk("tmo_err",   o_err, 1'b1);
        i_psg_ready = 1'b1;
        wait_idle("idle_tmo", 100);
        chk("tmo_next_data",  q_data[1], 8'hA6);
        chk("tmo_next_width", q_width[1], 2);
        chk("err_sticky",     o_err, 1'b1);

        // flush during a long wait with writes queued
        mon_clear();
        push(1'b1, 16'd1000);
        push(1'b0, 16'h00C1);
        push(1'b0, 16'h00C2);
        push(1'b0, 16'h00C3);
        chk("pre_flush_level", o_level, 4'd3);
        chk("pre_flush_busy",  o_busy, 1'b1);
        i_flush = 1'b1;
        sync();
        i_flush = 1'b0;
        chk("flush_level", o_level, 4'd0);
        chk("flush_busy",  o_busy, 1'b0);
        for (int i = 0; i < 30; i++) sync();
        chk("flush_nostrobe", q_fall.size(), 0);
        chk("flush_still_idle", o_busy, 1'b0);

        // asynchronous reset in the middle of a strobe
        i_psg_ready = 1'b0;
        push(1'b0, 16'h0077);
        push(1'b0, 16'h0078);
        n = 0;
        while (o_psg_we_n && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        chk("rst_mid_strobe_low", o_psg_we_n, 1'b0);
        chk("rst_mid_level",      o_level, 4'd1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_we_n",  o_psg_we_n, 1'b1);
        chk("arst_level", o_level, 4'd0);
        chk("arst_err",   o_err, 1'b0);
        chk("arst_data",  o_psg_data, 8'h00);
        #4 i_rst_n = 1'b1;
        i_psg_ready = 1'b1;
        sync();
        chk("post_rst_busy", o_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/psg_cmd_player.md
# psg_cmd_player

Parametrised command player that feeds the SN76489 PSG core through its byte-write port. Buffers a stream of write-byte and wait commands in a FIFO, then replays them with cycle-exact inter-write delays and a correct write-strobe/READY handshake. Sits between a host, cocotb bench or on-chip sequencer and `tt_um_rejunity_sn76489`, so register sequences play back without per-cycle host control.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `WAIT_W`, 16: command argument width; ≥8.
- `WR_HOLD`, 2: minimum cycles `psg_we_n` stays low; ≥1.
- `TIMEOUT`, 64: maximum strobe cycles waiting for `psg_ready`; must exceed `WR_HOLD`.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: run enable; 0 pauses playback.
- `flush` in 1: synchronous; empties the FIFO and aborts any wait.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO can accept a command.
- `cmd_op` in 1: 0 = WRITE (byte is `cmd_arg[7:0]`), 1 = WAIT (`cmd_arg` cycles).
- `cmd_arg` in WAIT_W: command argument.
- `psg_data` out 8: byte presented to the PSG.
- `psg_we_n` out 1: active-low write strobe.
- `psg_ready` in 1: PSG has accepted the byte.
- `busy` out 1: FSM is not in IDLE, or the FIFO is not empty.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.
- `err` out 1: sticky strobe timeout; cleared only by reset.

## Operation
- Push on `cmd_valid && cmd_ready`.
- `cmd_ready = !full`. It does not account for a same-cycle pop.
- No bypass: a command pushed into an empty FIFO is poppable on the next cycle.
- FSM states: IDLE, SETUP, STROBE, RECOVER, WAIT.
- IDLE: if `ena`, FIFO not empty and no `flush`, pop the head into the current-command register.
  - WRITE goes to SETUP.
  - WAIT with arg N>0 goes to WAIT with counter = N.
  - WAIT with N=0 stays in IDLE; it costs one cycle.
- SETUP: `psg_data` = byte, `psg_we_n` = 1, for one cycle; then STROBE.
- STROBE: `psg_we_n` = 0.
  - Leave once at least `WR_HOLD` cycles have elapsed and `psg_ready` = 1, sampled in the same cycle; go to RECOVER.
  - If `TIMEOUT` cycles elapse without that, set `err` and go to RECOVER.
- RECOVER: `psg_we_n` = 1 for one cycle; `psg_data` holds its value; then IDLE.
- WAIT: counter decrements by 1 each cycle while `ena`; at 1 → IDLE.
- `ena` = 0:
  - Blocks pops and freezes the WAIT counter.
  - SETUP, STROBE and RECOVER still run to completion, so a write is never torn.
- `flush`:
  - Clears the FIFO, with `level` = 0 next cycle.
  - Forces WAIT to IDLE.
  - A write already in SETUP, STROBE or RECOVER completes.
  - `flush` wins over a same-cycle push, which is dropped.
- Arithmetic: pointers wrap modulo DEPTH; `level` is the pointer difference with a wrap bit; the WAIT counter is WAIT_W bits, unsigned.

## Timing
- Reset values (asynchronous): FSM = IDLE, FIFO empty, `psg_we_n` = 1, `psg_data` = 0, `cmd_ready` = 1, `busy` = 0, `level` = 0, `err` = 0.
- A write popped at cycle t: SETUP at t+1, `psg_we_n` low from t+2.
  - With `psg_ready` already high: low for exactly `WR_HOLD` cycles, high again at t+2+WR_HOLD, IDLE at t+3+WR_HOLD.
  - Back-to-back writes with `WR_HOLD` = 2 and `psg_ready` = 1: one write per 5 cycles.
- WAIT N popped at cycle t: next pop at cycle t+N+1 (with `ena` held high).
- All outputs are registered except `cmd_ready`, `busy` and `level`, which decode registered state.
- `rst_n` falling mid-strobe forces `psg_we_n` = 1 immediately, without waiting for a clock edge.

## Structure
- Package `psg_player_pkg` holds:
  - the state enum;
  - the `OP_WRITE` / `OP_WAIT` constants;
  - a packed command typedef {op, arg} parametrised via WAIT_W.
- Sub-module `psg_cmd_fifo`: synchronous FIFO with DEPTH, a width parameter, flush, and `level`/full/empty outputs.
- The top module holds the FSM and the WAIT and strobe counters.

## Test plan
- Reset, then push WRITE 0x9F, WRITE 0x80 with `psg_ready` tied 1 → `psg_data` 0x9F then 0x80; each `psg_we_n` low exactly 2 cycles; strobe falling edges 5 cycles apart.
- Push WRITE 0x90, WAIT 10, WRITE 0x91 → the second strobe's falling edge comes 16 cycles after the first (5 write + 11 wait cycles).
- Push 8 commands with `ena` = 0 → `level` = 8, `cmd_ready` = 0, a 9th push is ignored; raise `ena` → all 8 replay in order.
- Hold `psg_ready` = 0 → `psg_we_n` low for 64 cycles, then `err` = 1; the next command still plays.
- During WAIT 1000 with 3 commands queued, assert `flush` → IDLE next cycle, `level` = 0, no further strobes, `busy` = 0.
- Assert `rst_n` = 0 while in STROBE → `psg_we_n` = 1 immediately, `level` = 0, `err` = 0.
